// File: rtl/elevator_call_scheduler.sv
// Four-floor elevator call scheduler.
// Latches car and hall calls, picks the next target floor in the current
// travel direction, commands door openings and flags a stuck car.
module elevator_call_scheduler #(
  parameter int MOVE_LIMIT = 200
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] car_btn,
  input  logic [2:0] hall_up,
  input  logic [2:0] hall_dn,
  input  logic [1:0] cur_floor,
  input  logic       arrived,
  input  logic       door_done,
  output logic [1:0] target_floor,
  output logic       target_valid,
  output logic       direction,
  output logic       rest,
  output logic       open_req,
  output logic [3:0] pending,
  output logic       fault
);

  typedef enum logic [1:0] {IDLE, MOVE, DOOR, FAULT} state_t;

  state_t     state_q, state_d;
  logic [3:0] car_req_q, car_req_d;
  logic [2:0] up_req_q, up_req_d;
  logic [2:0] dn_req_q, dn_req_d;
  logic [1:0] target_q, target_d;
  logic       target_valid_q, target_valid_d;
  logic       dir_q, dir_d;
  logic       rest_q, rest_d;
  logic       open_q, open_d;
  logic [3:0] pending_q, pending_d;
  logic       fault_q, fault_d;
  logic [7:0] move_cnt_q, move_cnt_d;

  logic [3:0] car_f, up_f, dn_f, any_f;
  logic [3:0] above_cur, below_cur, further;
  logic [1:0] tgt_up, tgt_dn, move_tgt;
  logic       found_up, found_dn, move_found;
  logic [1:0] clr_floor;
  logic [3:0] clr_onehot;
  logic       clr_car_en, clr_up_en, clr_dn_en;

  function automatic logic [3:0] above_mask(input logic [1:0] f);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i > int'(f));
    return m;
  endfunction

  function automatic logic [3:0] below_mask(input logic [1:0] f);
    logic [3:0] m;
    for (int i = 0; i < 4; i++) m[i] = (i < int'(f));
    return m;
  endfunction

  function automatic logic [1:0] lowest_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 3; i >= 0; i--) if (v[i]) r = 2'(i);
    return r;
  endfunction

  function automatic logic [1:0] highest_set(input logic [3:0] v);
    logic [1:0] r;
    r = 2'd0;
    for (int i = 0; i < 4; i++) if (v[i]) r = 2'(i);
    return r;
  endfunction

  // Per-floor request views and the candidate target in each direction.
  always_comb begin
    car_f     = car_req_q;
    up_f      = {1'b0, up_req_q};
    dn_f      = {dn_req_q, 1'b0};
    any_f     = car_f | up_f | dn_f;
    above_cur = above_mask(cur_floor);
    below_cur = below_mask(cur_floor);
    found_up  = 1'b0;
    tgt_up    = 2'd0;
    found_dn  = 1'b0;
    tgt_dn    = 2'd0;
    if (|((car_f | up_f) & above_cur)) begin
      found_up = 1'b1;
      tgt_up   = lowest_set((car_f | up_f) & above_cur);
    end else if (|(dn_f & above_cur)) begin
      found_up = 1'b1;
      tgt_up   = highest_set(dn_f & above_cur);
    end
    if (|((car_f | dn_f) & below_cur)) begin
      found_dn = 1'b1;
      tgt_dn   = highest_set((car_f | dn_f) & below_cur);
    end else if (|(up_f & below_cur)) begin
      found_dn = 1'b1;
      tgt_dn   = lowest_set(up_f & below_cur);
    end
  end

  // Next-state logic: scheduling decisions, door commands and request clears.
  // Arrival is matched against the registered target so that the car reaching
  // its target floor is not lost when the strictly-ahead search moves on.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    dir_d      = dir_q;
    open_d     = 1'b0;
    move_cnt_d = move_cnt_q;
    clr_floor  = cur_floor;
    clr_car_en = 1'b0;
    clr_up_en  = 1'b0;
    clr_dn_en  = 1'b0;
    further    = 4'b0000;
    move_tgt   = dir_q ? tgt_up : tgt_dn;
    move_found = dir_q ? found_up : found_dn;
    case (state_q)
      IDLE: begin
        if (any_f[cur_floor]) begin
          state_d    = DOOR;
          open_d     = 1'b1;
          clr_car_en = 1'b1;
          clr_up_en  = 1'b1;
          clr_dn_en  = 1'b1;
        end else if (|any_f) begin
          dir_d      = dir_q ? (|(any_f & above_cur)) : ~(|(any_f & below_cur));
          state_d    = MOVE;
          move_cnt_d = 8'd0;
          target_d   = dir_d ? tgt_up : tgt_dn;
        end
      end
      MOVE: begin
        move_cnt_d = move_cnt_q + 8'd1;
        if (!(|any_f)) begin
          state_d = IDLE;
        end else if (arrived && (cur_floor == target_q)) begin
          state_d    = DOOR;
          open_d     = 1'b1;
          clr_floor  = target_q;
          clr_car_en = 1'b1;
          further    = dir_q ? above_mask(target_q) : below_mask(target_q);
          if (dir_q) begin
            clr_up_en = 1'b1;
            clr_dn_en = !(|(any_f & further));
          end else begin
            clr_dn_en = 1'b1;
            clr_up_en = !(|(any_f & further));
          end
        end else begin
          if (move_found) target_d = move_tgt;
          if (move_cnt_q == 8'(MOVE_LIMIT - 1)) state_d = FAULT;
        end
      end
      DOOR: begin
        if (door_done) state_d = IDLE;
      end
      FAULT: begin
        state_d = FAULT;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Request latches (clear beats set) and the registered status outputs.
  always_comb begin
    clr_onehot = 4'b0001 << clr_floor;
    car_req_d  = car_req_q;
    up_req_d   = up_req_q;
    dn_req_d   = dn_req_q;
    if (state_q != FAULT) begin
      car_req_d = (car_req_q | car_btn) & ~(clr_car_en ? clr_onehot : 4'b0000);
      up_req_d  = (up_req_q | hall_up) & ~(clr_up_en ? clr_onehot[2:0] : 3'b000);
      dn_req_d  = (dn_req_q | hall_dn) & ~(clr_dn_en ? clr_onehot[3:1] : 3'b000);
    end
    pending_d      = car_req_d | {1'b0, up_req_d} | {dn_req_d, 1'b0};
    target_valid_d = (state_d == MOVE);
    rest_d         = (state_d == IDLE) && !(|pending_d);
    fault_d        = (state_d == FAULT);
  end

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q        <= IDLE;
      car_req_q      <= 4'b0000;
      up_req_q       <= 3'b000;
      dn_req_q       <= 3'b000;
      target_q       <= 2'd0;
      target_valid_q <= 1'b0;
      dir_q          <= 1'b1;
      rest_q         <= 1'b1;
      open_q         <= 1'b0;
      pending_q      <= 4'b0000;
      fault_q        <= 1'b0;
      move_cnt_q     <= 8'd0;
    end else begin
      state_q        <= state_d;
      car_req_q      <= car_req_d;
      up_req_q       <= up_req_d;
      dn_req_q       <= dn_req_d;
      target_q       <= target_d;
      target_valid_q <= target_valid_d;
      dir_q          <= dir_d;
      rest_q         <= rest_d;
      open_q         <= open_d;
      pending_q      <= pending_d;
      fault_q        <= fault_d;
      move_cnt_q     <= move_cnt_d;
    end
  end

  assign target_floor = target_q;
  assign target_valid = target_valid_q;
  assign direction    = dir_q;
  assign rest         = rest_q;
  assign open_req     = open_q;
  assign pending      = pending_q;
  assign fault        = fault_q;

endmodule

// File: tb/tb_elevator_call_scheduler.sv
// Directed testbench for elevator_call_scheduler with hand-computed expectations.
module tb_elevator_call_scheduler;

  logic       clock;
  logic       reset;
  logic [3:0] car_btn;
  logic [2:0] hall_up;
  logic [2:0] hall_dn;
  logic [1:0] cur_floor;
  logic       arrived;
  logic       door_done;
  logic [1:0] target_floor;
  logic       target_valid;
  logic       direction;
  logic       rest;
  logic       open_req;
  logic [3:0] pending;
  logic       fault;

  int checks;
  int errors;

  elevator_call_scheduler #(.MOVE_LIMIT(200)) dut (
    .clock       (clock),
    .reset       (reset),
    .car_btn     (car_btn),
    .hall_up     (hall_up),
    .hall_dn     (hall_dn),
    .cur_floor   (cur_floor),
    .arrived     (arrived),
    .door_done   (door_done),
    .target_floor(target_floor),
    .target_valid(target_valid),
    .direction   (direction),
    .rest        (rest),
    .open_req    (open_req),
    .pending     (pending),
    .fault       (fault)
  );

  // Free-running clock, rising edge active.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Safety net so the run can never hang.
  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation did not complete, got running expected finished");
    $fatal(1, "[TB] timeout");
  end

  task automatic applyStimulus(input logic [3:0] car, input logic [2:0] up,
                               input logic [2:0] dn, input logic [1:0] floor,
                               input logic arr, input logic dd);
    car_btn   = car;
    hall_up   = up;
    hall_dn   = dn;
    cur_floor = floor;
    arrived   = arr;
    door_done = dd;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [3:0] got, input logic [3:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic checkAll(input string tag, input logic [3:0] e_pend, input logic [1:0] e_tf,
                          input logic e_tv, input logic e_dir, input logic e_rest,
                          input logic e_open, input logic e_fault);
    checkOutput({tag, ".pending"},      pending,              e_pend);
    checkOutput({tag, ".target_floor"}, {2'b00, target_floor}, {2'b00, e_tf});
    checkOutput({tag, ".target_valid"}, {3'b000, target_valid}, {3'b000, e_tv});
    checkOutput({tag, ".direction"},    {3'b000, direction},  {3'b000, e_dir});
    checkOutput({tag, ".rest"},         {3'b000, rest},       {3'b000, e_rest});
    checkOutput({tag, ".open_req"},     {3'b000, open_req},   {3'b000, e_open});
    checkOutput({tag, ".fault"},        {3'b000, fault},      {3'b000, e_fault});
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b0;
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step(2);
    checkAll("reset", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;
    step(1);
    checkAll("idle", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Car call to floor 4 from floor 1, hall-up call at floor 2 picked up on the way.
    applyStimulus(4'b1000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step(1);
    checkAll("latch_car3", 4'b1000, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step(1);
    checkAll("move_up", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b010, 3'b000, 2'd0, 1'b0, 1'b0);
    step(1);
    checkAll("latch_up1", 4'b1010, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step(1);
    checkAll("retarget_1", 4'b1010, 2'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0);
    step(1);
    checkAll("arrive_1", 4'b1000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
    step(1);
    checkAll("door_hold", 4'b1000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b0, 1'b1);
    step(1);
    checkAll("door_done", 4'b1000, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
    step(1);
    checkAll("resume_up", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0);
    step(1);
    checkAll("stray_arrive", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd3, 1'b1, 1'b0);
    step(1);
    checkAll("arrive_3", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b1);
    step(1);
    checkAll("rest_again", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Hall-down call at the idle car's own floor: straight to DOOR, clear beats held button.
    applyStimulus(4'b0000, 3'b000, 3'b010, 2'd2, 1'b0, 1'b0);
    step(1);
    checkAll("latch_dn3", 4'b0100, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    checkAll("door_here", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
    step(1);
    checkAll("open_once", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b1);
    step(1);
    checkAll("idle_floor3", 4'b0000, 2'd3, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);

    // Only calls below: direction reverses, then a car call takes priority over hall-up.
    applyStimulus(4'b0000, 3'b011, 3'b000, 2'd2, 1'b0, 1'b0);
    step(1);
    checkAll("latch_up01", 4'b0011, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
    step(1);
    checkAll("reverse_dn", 4'b0011, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0010, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
    step(1);
    checkAll("latch_car1", 4'b0011, 2'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd2, 1'b0, 1'b0);
    step(1);
    checkAll("retarget_dn1", 4'b0011, 2'd1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b1, 1'b0);
    step(1);
    checkAll("arrive_dn1", 4'b0011, 2'd1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);

    // Reset in DOOR drops everything at once and never produces an open pulse.
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd1, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    checkAll("reset_door", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    checkAll("reset_hold", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    reset = 1'b1;

    // Car never arrives: timeout after 200 MOVE clocks, then frozen until reset.
    applyStimulus(4'b1000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step(1);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd0, 1'b0, 1'b0);
    step(1);
    checkAll("fault_move", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(199);
    checkAll("pre_fault", 4'b1000, 2'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1);
    checkAll("fault_set", 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0001, 3'b000, 3'b000, 2'd3, 1'b1, 1'b0);
    step(1);
    checkAll("fault_frozen", 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    applyStimulus(4'b0000, 3'b000, 3'b000, 2'd3, 1'b0, 1'b0);
    step(3);
    checkAll("fault_sticky", 4'b1000, 2'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    reset = 1'b0;
    #1;
    checkAll("fault_reset", 4'b0000, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    step(1);
    reset = 1'b1;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
